// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the Mastermind turn sequencer.
// Feedback digit codes, FSM state encoding and the scoring schedule length.
package game_ctrl_pkg;

  localparam int NUM_PEGS    = 4;
  localparam int EXACT_STEPS = 4;
  localparam int PART_STEPS  = 16;
  localparam int SCORE_STEPS = EXACT_STEPS + PART_STEPS;

  localparam logic [1:0] FB_BLANK = 2'd0;
  localparam logic [1:0] FB_COLOR = 2'd1;
  localparam logic [1:0] FB_EXACT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GUESS,
    S_SCORE_EXACT,
    S_SCORE_PART,
    S_PUBLISH,
    S_WON,
    S_LOST
  } state_t;

  // Exact pegs fill the leftmost digits, colour-only matches follow, rest blank.
  function automatic logic [2*NUM_PEGS-1:0] fb_pack(input logic [2:0] exact,
                                                    input logic [2:0] partial);
    logic [2*NUM_PEGS-1:0] res;
    logic [3:0]            sum;
    res = '0;
    sum = {1'b0, exact} + {1'b0, partial};
    for (int k = 0; k < NUM_PEGS; k++) begin
      if (4'(k) < {1'b0, exact})  res[2*k +: 2] = FB_EXACT;
      else if (4'(k) < sum)       res[2*k +: 2] = FB_COLOR;
      else                        res[2*k +: 2] = FB_BLANK;
    end
    return res;
  endfunction

endpackage

// File: rtl/game_ctrl_peg_scorer.sv
// Iterative exact/partial scorer: 4 exact steps then 16 partial steps, fixed 20 cycles after go.
// done_o is combinational in the last step; exact_o/partial_o are final while done_o is high.
module peg_scorer
  import game_ctrl_pkg::*;
#(
  parameter int COLOR_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go_i,
  input  logic [NUM_PEGS*COLOR_W-1:0]   guess_i,
  input  logic [NUM_PEGS*COLOR_W-1:0]   secret_i,
  output logic                          exact_last_o,
  output logic                          done_o,
  output logic [2:0]                    exact_o,
  output logic [2:0]                    partial_o
);

  logic                active_q, active_d;
  logic [4:0]          step_q, step_d;
  logic [2:0]          exact_q, exact_d;
  logic [2:0]          partial_q, partial_d;
  logic [NUM_PEGS-1:0] used_g_q, used_g_d;
  logic [NUM_PEGS-1:0] used_c_q, used_c_d;
  logic                found_q, found_d;

  logic [1:0] idx, pi, pj;
  logic [3:0] part_s;
  logic       found_cur;

  assign idx    = step_q[1:0];
  assign part_s = step_q[3:0] - 4'd4;
  assign pi     = part_s[3:2];
  assign pj     = part_s[1:0];

  always_comb begin
    active_d  = active_q;
    step_d    = step_q;
    exact_d   = exact_q;
    partial_d = partial_q;
    used_g_d  = used_g_q;
    used_c_d  = used_c_q;
    found_d   = found_q;
    found_cur = found_q;
    if (go_i) begin
      active_d  = 1'b1;
      step_d    = '0;
      exact_d   = '0;
      partial_d = '0;
      used_g_d  = '0;
      used_c_d  = '0;
      found_d   = 1'b0;
    end else if (active_q) begin
      if (step_q < 5'(EXACT_STEPS)) begin
        if (guess_i[idx*COLOR_W +: COLOR_W] == secret_i[idx*COLOR_W +: COLOR_W]) begin
          exact_d       = exact_q + 3'd1;
          used_g_d[idx] = 1'b1;
          used_c_d[idx] = 1'b1;
        end
      end else begin
        // found only suppresses repeat matches for the same guess peg
        found_cur = (pj == 2'd0) ? 1'b0 : found_q;
        found_d   = found_cur;
        if (!used_g_q[pi] && !used_c_q[pj] && !found_cur &&
            guess_i[pi*COLOR_W +: COLOR_W] == secret_i[pj*COLOR_W +: COLOR_W]) begin
          partial_d    = partial_q + 3'd1;
          used_c_d[pj] = 1'b1;
          found_d      = 1'b1;
        end
      end
      if (step_q == 5'(SCORE_STEPS - 1)) active_d = 1'b0;
      else                               step_d   = step_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      step_q    <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      used_g_q  <= '0;
      used_c_q  <= '0;
      found_q   <= 1'b0;
    end else begin
      active_q  <= active_d;
      step_q    <= step_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      used_g_q  <= used_g_d;
      used_c_q  <= used_c_d;
      found_q   <= found_d;
    end
  end

  assign exact_last_o = active_q && (step_q == 5'(EXACT_STEPS - 1));
  assign done_o       = active_q && (step_q == 5'(SCORE_STEPS - 1));
  assign exact_o      = exact_q;
  assign partial_o    = partial_d;

endmodule

// File: rtl/game_ctrl.sv
// Mastermind turn sequencer: latches the secret, scores each guess, publishes feedback/history.
// Select to fb_valid/hist_wr is 21 cycles; selects and starts during scoring are dropped.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int MAX_TURNS = 8,
  parameter int COLOR_W   = 3,
  parameter int TURN_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               select,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess3,
  input  logic [COLOR_W-1:0] code0,
  input  logic [COLOR_W-1:0] code1,
  input  logic [COLOR_W-1:0] code2,
  input  logic [COLOR_W-1:0] code3,
  output logic               busy,
  output logic [TURN_W-1:0]  turn,
  output logic               hist_wr,
  output logic [TURN_W-1:0]  hist_turn,
  output logic [COLOR_W-1:0] hist_peg0,
  output logic [COLOR_W-1:0] hist_peg1,
  output logic [COLOR_W-1:0] hist_peg2,
  output logic [COLOR_W-1:0] hist_peg3,
  output logic [1:0]         fb0,
  output logic [1:0]         fb1,
  output logic [1:0]         fb2,
  output logic [1:0]         fb3,
  output logic               fb_valid,
  output logic               game_won,
  output logic               game_lost
);

  localparam int PW = NUM_PEGS * COLOR_W;

  state_t                state_q;
  logic [PW-1:0]         secret_q;
  logic [PW-1:0]         guess_q;
  logic [PW-1:0]         hist_peg_q;
  logic [TURN_W-1:0]     turn_q;
  logic [TURN_W-1:0]     hist_turn_q;
  logic [2*NUM_PEGS-1:0] fb_q;
  logic                  fb_valid_q, hist_wr_q, busy_q, won_q, lost_q;

  logic       go, sc_exact_last, sc_done;
  logic [2:0] sc_exact, sc_partial;

  assign go = (state_q == S_GUESS) && select;

  peg_scorer #(.COLOR_W(COLOR_W)) u_scorer (
    .clk          (clk),
    .reset        (reset),
    .go_i         (go),
    .guess_i      (guess_q),
    .secret_i     (secret_q),
    .exact_last_o (sc_exact_last),
    .done_o       (sc_done),
    .exact_o      (sc_exact),
    .partial_o    (sc_partial)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      secret_q    <= '0;
      guess_q     <= '0;
      hist_peg_q  <= '0;
      turn_q      <= '0;
      hist_turn_q <= '0;
      fb_q        <= '0;
      fb_valid_q  <= 1'b0;
      hist_wr_q   <= 1'b0;
      busy_q      <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      fb_valid_q <= 1'b0;
      hist_wr_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_WON, S_LOST: begin
          if (start) state_q <= S_LATCH;
        end
        S_LATCH: begin
          secret_q <= {code3, code2, code1, code0};
          turn_q   <= '0;
          fb_q     <= '0;
          won_q    <= 1'b0;
          lost_q   <= 1'b0;
          state_q  <= S_GUESS;
        end
        S_GUESS: begin
          if (select) begin
            guess_q <= {guess3, guess2, guess1, guess0};
            busy_q  <= 1'b1;
            state_q <= S_SCORE_EXACT;
          end
        end
        S_SCORE_EXACT: begin
          if (sc_exact_last) state_q <= S_SCORE_PART;
        end
        S_SCORE_PART: begin
          if (sc_done) begin
            fb_q        <= fb_pack(sc_exact, sc_partial);
            fb_valid_q  <= 1'b1;
            hist_wr_q   <= 1'b1;
            hist_turn_q <= turn_q;
            hist_peg_q  <= guess_q;
            state_q     <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          busy_q <= 1'b0;
          // rightmost digit is exact only when all four pegs matched
          if (fb_q[2*NUM_PEGS-1 -: 2] == FB_EXACT) begin
            won_q   <= 1'b1;
            state_q <= S_WON;
          end else if (turn_q == TURN_W'(MAX_TURNS - 1)) begin
            lost_q  <= 1'b1;
            state_q <= S_LOST;
          end else begin
            turn_q  <= turn_q + TURN_W'(1);
            state_q <= S_GUESS;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign turn      = turn_q;
  assign hist_wr   = hist_wr_q;
  assign hist_turn = hist_turn_q;
  assign hist_peg0 = hist_peg_q[0*COLOR_W +: COLOR_W];
  assign hist_peg1 = hist_peg_q[1*COLOR_W +: COLOR_W];
  assign hist_peg2 = hist_peg_q[2*COLOR_W +: COLOR_W];
  assign hist_peg3 = hist_peg_q[3*COLOR_W +: COLOR_W];
  assign fb0       = fb_q[1:0];
  assign fb1       = fb_q[3:2];
  assign fb2       = fb_q[5:4];
  assign fb3       = fb_q[7:6];
  assign fb_valid  = fb_valid_q;
  assign game_won  = won_q;
  assign game_lost = lost_q;

endmodule
